cdb_arbiter_mc: RTL and testbench

- Multi-channel writeback arbiter between N functional-unit writeback ports and the single-entry CDB consumed by commit_rename and the PRF.
- Each channel has a small FIFO. A registered output stage, round-robin arbitration and mispredict-first priority sit behind the FIFOs.
- Squashes writebacks younger than a flush point by ROB age.
- Lets the execute cluster scale FU count without combinational ready chains back into the FUs.

---
 rtl/cdb_arbiter_mc_if.sv | 63 ++++++
 rtl/cdb_arbiter_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_cdb_arbiter_mc.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_mc_if.sv
// Packet type and handshake interface for the multi-channel CDB writeback arbiter.
//
// cdb_arbiter_mc_pkg
//   fu_wb_t : functional-unit writeback packet. The arbiter reads only
//             rob_idx, is_branch and mispredict. pdst and data travel
//             through unchanged.
//
// cdb_arbiter_mc_if (parameter NUM_CH)
//   ch_valid  [NUM_CH]     FU -> arbiter  writeback valid, one bit per channel
//   ch_ready  [NUM_CH]     arbiter -> FU  per-channel accept
//   ch_pkt    [NUM_CH]     FU -> arbiter  writeback packets
//   cdb_valid              arbiter -> CDB packet valid
//   cdb_ready              CDB -> arbiter consumer accept
//   cdb_pkt                arbiter -> CDB registered packet
//   modport slave  : the arbiter side
//   modport master : the FU cluster / CDB consumer side

package cdb_arbiter_mc_pkg;

    // ROB index width carried inside the packet. The arbiter's ROB_W parameter must match it.
    localparam int ROB_W_P = 5;

    typedef struct packed {
        logic [ROB_W_P-1:0] rob_idx;
        logic [6:0]         pdst;
        logic [31:0]        data;
        logic               is_branch;
        logic               mispredict;
    } fu_wb_t;

endpackage

interface cdb_arbiter_mc_if #(
    parameter int NUM_CH = 4
);
    import cdb_arbiter_mc_pkg::*;

    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH-1:0]         ch_ready;
    fu_wb_t [NUM_CH-1:0]       ch_pkt;
    logic                      cdb_valid;
    logic                      cdb_ready;
    fu_wb_t                    cdb_pkt;

    modport slave (
        input  ch_valid,
        input  ch_pkt,
        input  cdb_ready,
        output ch_ready,
        output cdb_valid,
        output cdb_pkt
    );

    modport master (
        output ch_valid,
        output ch_pkt,
        output cdb_ready,
        input  ch_ready,
        input  cdb_valid,
        input  cdb_pkt
    );

endinterface

// File: rtl/cdb_arbiter_mc.sv
// Multi-channel writeback arbiter. It merges NUM_CH functional-unit writeback
// ports onto one registered CDB slot.
//
// Each channel has a Q_DEPTH FIFO. The FIFO is stored compacted, with the head
// always in slot 0. This lets a flush drop arbitrary entries and keep the
// survivors in order without pointer bookkeeping. Arbitration is round-robin
// among the non-empty heads, and a mispredicted branch head takes priority.
// ch_ready comes only from registered FIFO counts, so no ready path reaches
// back combinationally into the FUs.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   bus               cdb_arbiter_mc_if.slave (channel and CDB handshakes)
//   rob_head          ROB commit pointer; ages are measured from it
//   flush_valid       squash request
//   flush_rob_idx     flush point; strictly younger entries are dropped
//   busy              any FIFO entry or the output slot is occupied
//   drop_count        saturating count of squashed packets

module cdb_arbiter_mc
    import cdb_arbiter_mc_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int Q_DEPTH = 2,
    parameter int ROB_W   = ROB_W_P,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cdb_arbiter_mc_if.slave      bus,
    input  logic [ROB_W-1:0]     rob_head,
    input  logic                 flush_valid,
    input  logic [ROB_W-1:0]     flush_rob_idx,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_count
);

    localparam int CW  = $clog2(Q_DEPTH + 1);
    localparam int QW  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CHW = $clog2(NUM_CH);
    // Enough bits for every FIFO entry, every same-cycle enqueue and the output slot.
    localparam int DW  = $clog2(NUM_CH * (Q_DEPTH + 1) + 2);

    // Younger-than-flush test on ROB age. The subtraction wraps at ROB_W bits by construction.
    function automatic logic is_younger(input logic [ROB_W-1:0] idx,
                                        input logic [ROB_W-1:0] fidx,
                                        input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] age_e;
        logic [ROB_W-1:0] age_f;
        age_e = idx - head;
        age_f = fidx - head;
        return (age_e > age_f);
    endfunction

    fu_wb_t            mem_r      [NUM_CH][Q_DEPTH];
    logic [CW-1:0]     count_r    [NUM_CH];
    logic [CHW-1:0]    rr_ptr_r;
    logic              out_valid_r;
    fu_wb_t            out_pkt_r;
    logic [CNT_W-1:0]  drop_r;

    logic [Q_DEPTH-1:0] surv_s     [NUM_CH];
    logic [NUM_CH-1:0]  cand_s;
    logic [NUM_CH-1:0]  mp_head_s;
    logic [NUM_CH-1:0]  elig_s;
    logic [NUM_CH-1:0]  ready_s;
    logic [QW-1:0]      head_pos_s [NUM_CH];
    fu_wb_t             head_pkt_s [NUM_CH];
    logic               grant_any_s;
    logic [CHW-1:0]     winner_s;
    logic [CHW-1:0]     idx_s;
    logic               out_squash_s;
    logic               load_s;
    logic               grant_s;
    fu_wb_t             nxt_mem_s   [NUM_CH][Q_DEPTH];
    logic [CW-1:0]      nxt_count_s [NUM_CH];
    logic [DW-1:0]      drop_s;
    logic [CNT_W:0]     drop_sum_s;
    logic [CNT_W-1:0]   drop_nxt_s;
    logic               any_count_s;

    // Per-channel ready, and the occupancy summary, from registered state only.
    always_comb begin
        any_count_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ready_s[i]  = (count_r[i] != CW'(Q_DEPTH));
            any_count_s = any_count_s | (count_r[i] != '0);
        end
    end

    // Flush survivors and the first surviving entry of each FIFO. The arbiter sees only this post-flush head.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cand_s[i]     = 1'b0;
            head_pos_s[i] = '0;
            head_pkt_s[i] = '0;
            for (int k = 0; k < Q_DEPTH; k++) begin
                surv_s[i][k] = (k < int'(count_r[i])) &&
                               !(flush_valid && is_younger(mem_r[i][k].rob_idx, flush_rob_idx, rob_head));
                if (surv_s[i][k] && !cand_s[i]) begin
                    cand_s[i]     = 1'b1;
                    head_pos_s[i] = QW'(k);
                    head_pkt_s[i] = mem_r[i][k];
                end else begin
                    cand_s[i] = cand_s[i];
                end
            end
            mp_head_s[i] = cand_s[i] && head_pkt_s[i].is_branch && head_pkt_s[i].mispredict;
        end
    end

    // Round-robin pick, restricted to mispredict heads when any exist. It gates the output-slot load.
    always_comb begin
        elig_s      = (|mp_head_s) ? mp_head_s : cand_s;
        grant_any_s = 1'b0;
        winner_s    = '0;
        idx_s       = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx_s = CHW'((int'(rr_ptr_r) + j) % NUM_CH);
            if (!grant_any_s && elig_s[idx_s]) begin
                grant_any_s = 1'b1;
                winner_s    = idx_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        // A squashed output slot empties this cycle and takes no new packet.
        out_squash_s = out_valid_r && flush_valid && is_younger(out_pkt_r.rob_idx, flush_rob_idx, rob_head);
        load_s       = !out_squash_s && (!out_valid_r || bus.cdb_ready);
        grant_s      = load_s && grant_any_s;
    end

    // Next FIFO contents: survivors minus the granted head, compacted to slot 0, then the accepted enqueue.
    always_comb begin
        drop_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nxt_count_s[i] = '0;
            for (int k = 0; k < Q_DEPTH; k++) begin
                nxt_mem_s[i][k] = '0;
            end
            for (int k = 0; k < Q_DEPTH; k++) begin
                if (surv_s[i][k] && !(grant_s && (winner_s == CHW'(i)) && (head_pos_s[i] == QW'(k)))) begin
                    nxt_mem_s[i][QW'(nxt_count_s[i])] = mem_r[i][k];
                    nxt_count_s[i] = nxt_count_s[i] + CW'(1);
                end else begin
                    nxt_count_s[i] = nxt_count_s[i];
                end
                if ((k < int'(count_r[i])) && !surv_s[i][k]) begin
                    drop_s = drop_s + DW'(1);
                end else begin
                    drop_s = drop_s;
                end
            end
            // An enqueue that is younger than a same-cycle flush is accepted, counted as dropped and not written.
            if (bus.ch_valid[i] && ready_s[i]) begin
                if (flush_valid && is_younger(bus.ch_pkt[i].rob_idx, flush_rob_idx, rob_head)) begin
                    drop_s = drop_s + DW'(1);
                end else begin
                    nxt_mem_s[i][QW'(nxt_count_s[i])] = bus.ch_pkt[i];
                    nxt_count_s[i] = nxt_count_s[i] + CW'(1);
                end
            end else begin
                nxt_count_s[i] = nxt_count_s[i];
            end
        end
        if (out_squash_s) begin
            drop_s = drop_s + DW'(1);
        end else begin
            drop_s = drop_s;
        end
        drop_sum_s = {1'b0, drop_r} + (CNT_W+1)'(drop_s);
        drop_nxt_s = drop_sum_s[CNT_W] ? {CNT_W{1'b1}} : drop_sum_s[CNT_W-1:0];
    end

    // FIFO storage, occupancy and the saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_r[i] <= '0;
                for (int k = 0; k < Q_DEPTH; k++) begin
                    mem_r[i][k] <= '0;
                end
            end
            drop_r <= '0;
        end else begin
            mem_r   <= nxt_mem_s;
            count_r <= nxt_count_s;
            drop_r  <= drop_nxt_s;
        end
    end

    // Output slot and round-robin pointer. The slot holds while a valid packet is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_pkt_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (out_squash_s) begin
            out_valid_r <= 1'b0;
            out_pkt_r   <= '0;
        end else if (load_s) begin
            if (grant_any_s) begin
                out_valid_r <= 1'b1;
                out_pkt_r   <= head_pkt_s[winner_s];
                rr_ptr_r    <= (winner_s == CHW'(NUM_CH - 1)) ? '0 : winner_s + CHW'(1);
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Output drive. Everything here comes straight from registers.
    always_comb begin
        bus.ch_ready  = ready_s;
        bus.cdb_valid = out_valid_r;
        bus.cdb_pkt   = out_pkt_r;
        busy          = any_count_s | out_valid_r;
        drop_count    = drop_r;
    end

endmodule

// File: tb/tb_cdb_arbiter_mc.sv
module tb_cdb_arbiter_mc;
    import cdb_arbiter_mc_pkg::*;

    localparam int N   = 4;
    localparam int QD  = 2;
    localparam int RW  = 5;
    localparam int CW  = 16;
    localparam int ROB = 1 << RW;

    logic            clk = 1'b0;
    logic            rst;
    logic [RW-1:0]   rob_head;
    logic            flush_valid;
    logic [RW-1:0]   flush_rob_idx;
    logic            busy;
    logic [CW-1:0]   drop_count;

    always #5 clk = ~clk;

    cdb_arbiter_mc_if #(.NUM_CH(N)) bus();

    cdb_arbiter_mc #(.NUM_CH(N), .Q_DEPTH(QD), .ROB_W(RW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .rob_head      (rob_head),
        .flush_valid   (flush_valid),
        .flush_rob_idx (flush_rob_idx),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    int checks   = 0;
    int failures = 0;
    int seq_ctr  = 0;

    // stimulus for the next cycle
    logic [N-1:0]      drv_valid;
    fu_wb_t [N-1:0]    drv_pkt;
    logic              drv_ready;
    logic              drv_flush;
    logic [RW-1:0]     drv_fidx;
    logic [RW-1:0]     drv_head;

    // reference model: per-channel queues plus one output slot
    fu_wb_t mq [N][$];
    bit     m_out_v;
    fu_wb_t m_out;
    int     m_rr;
    int     m_drop;
    fu_wb_t seen [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int age(input int x, input int h);
        return (x - h + ROB) % ROB;
    endfunction

    function automatic bit m_young(input int x, input int f, input int h);
        return age(x, h) > age(f, h);
    endfunction

    function automatic fu_wb_t mk(input int ch, input int rob, input bit br, input bit mp);
        fu_wb_t p;
        seq_ctr++;
        p.rob_idx    = RW'(rob);
        p.pdst       = 7'((ch % 4) * 32 + (seq_ctr % 32));
        p.data       = $urandom;
        p.is_branch  = br;
        p.mispredict = mp;
        return p;
    endfunction

    function automatic bit is_mp(input fu_wb_t p);
        return p.is_branch && p.mispredict;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_out_v = 1'b0;
        m_out   = '0;
        m_rr    = 0;
        m_drop  = 0;
    endtask

    task automatic set_idle();
        drv_valid = '0;
        drv_pkt   = '0;
        drv_ready = 1'b1;
        drv_flush = 1'b0;
        drv_fidx  = '0;
        drv_head  = '0;
    endtask

    task automatic apply_drive();
        bus.ch_valid  = drv_valid;
        bus.ch_pkt    = drv_pkt;
        bus.cdb_ready = drv_ready;
        flush_valid   = drv_flush;
        flush_rob_idx = drv_fidx;
        rob_head      = drv_head;
    endtask

    // Advance the model by one clock, applying the rules to the current stimulus.
    task automatic model_step();
        bit acc [N];
        bit squashed;
        bit any_mp;
        int w;
        int c;
        fu_wb_t keep [$];
        squashed = 1'b0;
        for (int i = 0; i < N; i++) acc[i] = drv_valid[i] && (mq[i].size() != QD);
        if (drv_flush) begin
            for (int i = 0; i < N; i++) begin
                keep.delete();
                foreach (mq[i][k]) begin
                    if (m_young(mq[i][k].rob_idx, drv_fidx, drv_head)) m_drop++;
                    else keep.push_back(mq[i][k]);
                end
                mq[i] = keep;
            end
            if (m_out_v && m_young(m_out.rob_idx, drv_fidx, drv_head)) begin
                m_out_v  = 1'b0;
                m_drop++;
                squashed = 1'b1;
            end
        end
        if (!squashed && (!m_out_v || drv_ready)) begin
            any_mp = 1'b0;
            for (int i = 0; i < N; i++)
                if (mq[i].size() > 0 && is_mp(mq[i][0])) any_mp = 1'b1;
            w = -1;
            for (int j = 0; j < N; j++) begin
                c = (m_rr + j) % N;
                if (w < 0 && mq[c].size() > 0 && (!any_mp || is_mp(mq[c][0]))) w = c;
            end
            if (w >= 0) begin
                m_out   = mq[w].pop_front();
                m_out_v = 1'b1;
                m_rr    = (w + 1) % N;
            end else begin
                m_out_v = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (drv_flush && m_young(drv_pkt[i].rob_idx, drv_fidx, drv_head)) m_drop++;
                else mq[i].push_back(drv_pkt[i]);
            end
        end
        if (m_drop > (1 << CW) - 1) m_drop = (1 << CW) - 1;
    endtask

    // One clock: check outputs against the model, drive the stimulus, advance the model.
    task automatic cycle();
        logic [N-1:0] er;
        bit eb;
        @(negedge clk);
        eb = m_out_v;
        for (int i = 0; i < N; i++) begin
            er[i] = (mq[i].size() != QD);
            if (mq[i].size() != 0) eb = 1'b1;
        end
        check_val("cdb_valid", bus.cdb_valid, m_out_v);
        if (m_out_v) check_val("cdb_pkt", bus.cdb_pkt, m_out);
        check_val("ch_ready", bus.ch_ready, er);
        check_val("busy", busy, eb);
        check_val("drop_count", drop_count, m_drop);
        if (bus.cdb_valid && drv_ready) seen.push_back(bus.cdb_pkt);
        apply_drive();
        model_step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        apply_drive();
        #1;
        check_val("rst_cdb_valid", bus.cdb_valid, 0);
        check_val("rst_drop", drop_count, 0);
        check_val("rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_seen(input string tag, input int exp [$], input bit by_rob);
        check_val({tag, "_count"}, seen.size(), exp.size());
        foreach (exp[k]) begin
            int obs;
            obs = -1;
            if (k < seen.size()) obs = by_rob ? int'(seen[k].rob_idx) : int'(seen[k].pdst[6:5]);
            check_val(tag, obs, exp[k]);
        end
    endtask

    initial begin
        int e [$];
        rst = 1'b1;
        set_idle();
        apply_drive();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single-packet latency
        drv_valid = 4'b0100;
        drv_pkt[2] = mk(2, 5, 1'b0, 1'b0);
        cycle();
        drv_valid = '0;
        cycle();
        cycle();
        check_val("lat_valid", bus.cdb_valid, 1);
        check_val("lat_rob", bus.cdb_pkt.rob_idx, 5);
        cycle();
        check_val("lat_busy", busy, 0);

        // round-robin with all FIFOs full
        apply_reset();
        drv_ready = 1'b0;
        drv_valid = '1;
        repeat (3) begin
            for (int i = 0; i < N; i++) drv_pkt[i] = mk(i, $urandom_range(0, 31), 1'b0, 1'b0);
            cycle();
        end
        drv_valid = '0;
        drv_ready = 1'b1;
        seen.delete();
        repeat (9) cycle();
        e = {0, 1, 2, 3, 0, 1, 2, 3, 0};
        check_seen("rr_order", e, 1'b0);

        // mispredict priority
        apply_reset();
        drv_ready  = 1'b0;
        drv_valid  = 4'b1011;
        drv_pkt[0] = mk(0, 4, 1'b1, 1'b0);
        drv_pkt[1] = mk(1, 6, 1'b0, 1'b0);
        drv_pkt[3] = mk(3, 8, 1'b1, 1'b1);
        cycle();
        drv_valid = '0;
        cycle();
        drv_ready = 1'b1;
        seen.delete();
        repeat (4) cycle();
        e = {3, 0, 1};
        check_seen("mp_order", e, 1'b0);

        // wrap-around flush
        apply_reset();
        drv_head   = 5'd30;
        drv_ready  = 1'b0;
        drv_valid  = 4'b1111;
        drv_pkt[0] = mk(0, 31, 1'b0, 1'b0);
        drv_pkt[1] = mk(1, 1, 1'b0, 1'b0);
        drv_pkt[2] = mk(2, 3, 1'b0, 1'b0);
        drv_pkt[3] = mk(3, 29, 1'b0, 1'b0);
        cycle();
        drv_valid = '0;
        cycle();
        drv_flush = 1'b1;
        drv_fidx  = 5'd2;
        cycle();
        drv_flush = 1'b0;
        drv_ready = 1'b1;
        seen.delete();
        repeat (5) cycle();
        e = {31, 1};
        check_seen("wrap_rob", e, 1'b1);
        check_val("wrap_drop", drop_count, 2);

        // backpressure with ch0 streaming
        apply_reset();
        drv_ready = 1'b0;
        drv_valid = 4'b0001;
        for (int t = 0; t < 5; t++) begin
            drv_pkt[0] = mk(0, t, 1'b0, 1'b0);
            cycle();
        end
        check_val("bp_ready0", bus.ch_ready[0], 0);
        drv_valid = '0;
        drv_ready = 1'b1;
        seen.delete();
        repeat (5) cycle();
        e = {0, 1, 2};
        check_seen("bp_rob", e, 1'b1);

        // reset in the middle of traffic
        apply_reset();
        drv_ready  = 1'b0;
        drv_valid  = 4'b0111;
        for (int i = 0; i < 3; i++) drv_pkt[i] = mk(i, 10 + i, 1'b0, 1'b0);
        cycle();
        drv_valid = '0;
        cycle();
        apply_reset();
        seen.delete();
        repeat (4) cycle();
        check_val("rst_no_stale", seen.size(), 0);

        // randomized traffic against the model
        apply_reset();
        repeat (3000) begin
            drv_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                drv_pkt[i] = mk(i, $urandom_range(0, ROB - 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            drv_ready = ($urandom_range(0, 3) != 0);
            drv_flush = ($urandom_range(0, 7) == 0);
            drv_fidx  = RW'($urandom);
            drv_head  = RW'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
